// File: rtl/alu_pkg.sv
// Shared definitions for the ALU op sequencer: ALU function codes, FSM states
// and a decode helper.
package alu_pkg;

  localparam logic [2:0] FS_ADD = 3'b000;
  localparam logic [2:0] FS_SUB = 3'b001;
  localparam logic [2:0] FS_SRA = 3'b010;
  localparam logic [2:0] FS_SRL = 3'b011;
  localparam logic [2:0] FS_SLL = 3'b100;
  localparam logic [2:0] FS_AND = 3'b101;
  localparam logic [2:0] FS_OR  = 3'b110;
  localparam logic [2:0] FS_NOP = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic is_shift(input logic [2:0] fs);
    return (fs == FS_SRA) || (fs == FS_SRL) || (fs == FS_SLL);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command, response and ALU-side signal bundle of the sequencer.
// slave is the sequencer's view; master is the surrounding system's view.
interface alu_op_sequencer_if #(
  parameter int WIDTH = 8
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_fs;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_y;
  logic             rsp_c;
  logic             rsp_z;
  logic             rsp_err;

  logic [2:0]       alu_fs;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_y;
  logic             alu_c;

  logic             busy;

  modport slave (
    input  cmd_valid, cmd_fs, cmd_a, cmd_b, rsp_ready, alu_y, alu_c,
    output cmd_ready, rsp_valid, rsp_y, rsp_c, rsp_z, rsp_err,
           alu_fs, alu_a, alu_b, busy
  );

  modport master (
    output cmd_valid, cmd_fs, cmd_a, cmd_b, rsp_ready, alu_y, alu_c,
    input  cmd_ready, rsp_valid, rsp_y, rsp_c, rsp_z, rsp_err,
           alu_fs, alu_a, alu_b, busy
  );

endinterface

// File: rtl/alu_shift_counter.sv
// Loadable down-counter tracking remaining 1-bit shift steps; o_last flags
// the final step.
module alu_shift_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  input  logic         i_dec,
  output logic         o_last
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_last = (r_count == W'(1));

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle sequencer in front of a single-cycle ALU; shifts by N are run
// as N back-to-back 1-bit ALU shifts.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input logic              clk,
  input logic              reset,
  alu_op_sequencer_if.slave bus
);

  state_t             r_state;
  logic               r_rsp_valid;
  logic [WIDTH-1:0]   r_rsp_y;
  logic               r_rsp_c;
  logic               r_rsp_z;
  logic               r_rsp_err;
  logic [2:0]         r_alu_fs;
  logic [WIDTH-1:0]   r_alu_a;
  logic [WIDTH-1:0]   r_alu_b;

  logic [SHAMT_W-1:0] w_amt;
  logic               w_load;
  logic               w_last;

  assign w_amt  = bus.cmd_b[SHAMT_W-1:0];
  assign w_load = (r_state == IDLE) && bus.cmd_valid && is_shift(bus.cmd_fs)
                  && (w_amt != '0);

  alu_shift_counter #(.W(SHAMT_W)) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_value (w_amt),
    .i_dec   (r_state == SHIFT),
    .o_last  (w_last)
  );

  // r_alu_a doubles as the shift accumulator while in SHIFT.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_rsp_valid <= 1'b0;
      r_rsp_y     <= '0;
      r_rsp_c     <= 1'b0;
      r_rsp_z     <= 1'b1;
      r_rsp_err   <= 1'b0;
      r_alu_fs    <= FS_NOP;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.cmd_valid) begin
            if (bus.cmd_fs == FS_NOP) begin
              r_rsp_y     <= '0;
              r_rsp_c     <= 1'b0;
              r_rsp_z     <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_valid <= 1'b1;
              r_state     <= DONE;
            end else if (is_shift(bus.cmd_fs)) begin
              if (w_amt == '0) begin
                r_rsp_y     <= bus.cmd_a;
                r_rsp_c     <= 1'b0;
                r_rsp_z     <= (bus.cmd_a == '0);
                r_rsp_valid <= 1'b1;
                r_state     <= DONE;
              end else begin
                r_alu_fs <= bus.cmd_fs;
                r_alu_a  <= bus.cmd_a;
                r_alu_b  <= '0;
                r_state  <= SHIFT;
              end
            end else begin
              r_alu_fs <= bus.cmd_fs;
              r_alu_a  <= bus.cmd_a;
              r_alu_b  <= bus.cmd_b;
              r_state  <= EXEC;
            end
          end
        end
        EXEC: begin
          r_rsp_y     <= bus.alu_y;
          r_rsp_c     <= bus.alu_c;
          r_rsp_z     <= (bus.alu_y == '0);
          r_rsp_valid <= 1'b1;
          r_alu_fs    <= FS_NOP;
          r_alu_a     <= '0;
          r_alu_b     <= '0;
          r_state     <= DONE;
        end
        SHIFT: begin
          r_alu_a <= bus.alu_y;
          r_rsp_c <= bus.alu_c;
          if (w_last) begin
            r_rsp_y     <= bus.alu_y;
            r_rsp_z     <= (bus.alu_y == '0);
            r_rsp_valid <= 1'b1;
            r_alu_fs    <= FS_NOP;
            r_alu_a     <= '0;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = (r_state == IDLE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_y     = r_rsp_y;
  assign bus.rsp_c     = r_rsp_c;
  assign bus.rsp_z     = r_rsp_z;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.alu_fs    = r_alu_fs;
  assign bus.alu_a     = r_alu_a;
  assign bus.alu_b     = r_alu_b;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer: a behavioural single-cycle ALU closes the
// loop, table vectors plus hand sequences for backpressure and mid-op reset.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  localparam int WIDTH = 8;

  typedef struct {
    logic [2:0]       fs;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] y;
    logic             c;
    logic             z;
    logic             err;
    int               lat;
    int               aluCyc;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] y;
    logic             c;
    logic             z;
    logic             err;
  } rsp_t;

  logic clk = 1'b0;
  logic reset;
  int   checkCount = 0;
  int   passCount  = 0;
  rsp_t expQ[$];
  vec_t vecs[13];

  always #5 clk = ~clk;

  alu_op_sequencer_if #(.WIDTH(WIDTH)) bus();

  alu_op_sequencer #(.WIDTH(WIDTH), .SHAMT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural model of the external single-cycle ALU datapath
  logic [WIDTH:0] aluSum;
  always_comb begin
    aluSum     = '0;
    bus.alu_y  = '0;
    bus.alu_c  = 1'b0;
    case (bus.alu_fs)
      FS_ADD: begin
        aluSum    = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        bus.alu_y = aluSum[WIDTH-1:0];
        bus.alu_c = aluSum[WIDTH];
      end
      FS_SUB: begin
        aluSum    = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + {{WIDTH{1'b0}}, 1'b1};
        bus.alu_y = aluSum[WIDTH-1:0];
        bus.alu_c = aluSum[WIDTH];
      end
      FS_SRA: begin
        bus.alu_y = {bus.alu_a[WIDTH-1], bus.alu_a[WIDTH-1:1]};
        bus.alu_c = bus.alu_a[0];
      end
      FS_SRL: begin
        bus.alu_y = {1'b0, bus.alu_a[WIDTH-1:1]};
        bus.alu_c = bus.alu_a[0];
      end
      FS_SLL: begin
        bus.alu_y = {bus.alu_a[WIDTH-2:0], 1'b0};
        bus.alu_c = bus.alu_a[WIDTH-1];
      end
      FS_AND: bus.alu_y = bus.alu_a & bus.alu_b;
      FS_OR:  bus.alu_y = bus.alu_a | bus.alu_b;
      default: ;
    endcase
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [2:0] fs, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] y, input logic c, input logic z,
                              input logic err, input int lat, input int aluCyc);
    vec_t v;
    v.fs = fs; v.a = a; v.b = b; v.y = y; v.c = c; v.z = z; v.err = err;
    v.lat = lat; v.aluCyc = aluCyc;
    return v;
  endfunction

  function automatic rsp_t expOf(input vec_t v);
    rsp_t r;
    r.y = v.y; r.c = v.c; r.z = v.z; r.err = v.err;
    return r;
  endfunction

  // Waits for rsp_valid; latency counts negedge samples after the accept edge
  task automatic waitResponse(input vec_t v);
    int lat = 1;
    int aluCyc = 0;
    int wrongFs = 0;
    while (!bus.rsp_valid && lat < 40) begin
      if (bus.alu_fs != FS_NOP) begin
        aluCyc++;
        if (bus.alu_fs != v.fs) wrongFs++;
      end
      @(negedge clk);
      lat++;
    end
    checkVal("rsp_valid_seen", 32'(bus.rsp_valid), 32'(1));
    checkVal("latency", 32'(lat), 32'(v.lat));
    checkVal("alu_active_cycles", 32'(aluCyc), 32'(v.aluCyc));
    checkVal("alu_fs_code", 32'(wrongFs), 32'(0));
  endtask

  task automatic applyStimulus(input vec_t v);
    int w = 0;
    @(negedge clk);
    while (!bus.cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_fs    = v.fs;
    bus.cmd_a     = v.a;
    bus.cmd_b     = v.b;
    expQ.push_back(expOf(v));
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    if (v.aluCyc > 0) begin
      checkVal("alu_a_first", 32'(bus.alu_a), 32'(v.a));
      checkVal("alu_b_first", 32'(bus.alu_b), is_shift(v.fs) ? 32'(0) : 32'(v.b));
    end
    waitResponse(v);
  endtask

  task automatic checkOutput(input string tag);
    rsp_t e;
    if (expQ.size() == 0) begin
      checkVal({tag, "_scoreboard_nonempty"}, 32'(0), 32'(1));
      return;
    end
    e = expQ.pop_front();
    checkVal({tag, "_y"},   32'(bus.rsp_y),   32'(e.y));
    checkVal({tag, "_c"},   32'(bus.rsp_c),   32'(e.c));
    checkVal({tag, "_z"},   32'(bus.rsp_z),   32'(e.z));
    checkVal({tag, "_err"}, 32'(bus.rsp_err), 32'(e.err));
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    checkVal({tag, "_valid_cleared"}, 32'(bus.rsp_valid), 32'(0));
    checkVal({tag, "_err_cleared"},   32'(bus.rsp_err),   32'(0));
    checkVal({tag, "_ready_again"},   32'(bus.cmd_ready), 32'(1));
  endtask

  task automatic checkResetState(input string tag);
    checkVal({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'(1));
    checkVal({tag, "_busy"},      32'(bus.busy),      32'(0));
    checkVal({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'(0));
    checkVal({tag, "_rsp_y"},     32'(bus.rsp_y),     32'(0));
    checkVal({tag, "_rsp_c"},     32'(bus.rsp_c),     32'(0));
    checkVal({tag, "_rsp_z"},     32'(bus.rsp_z),     32'(1));
    checkVal({tag, "_rsp_err"},   32'(bus.rsp_err),   32'(0));
    checkVal({tag, "_alu_fs"},    32'(bus.alu_fs),    32'(FS_NOP));
    checkVal({tag, "_alu_a"},     32'(bus.alu_a),     32'(0));
    checkVal({tag, "_alu_b"},     32'(bus.alu_b),     32'(0));
  endtask

  initial begin
    vec_t v;
    int   w;
    int   highs;

    vecs[0]  = mk(FS_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b0, 2, 1);
    vecs[1]  = mk(FS_SUB, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b0, 2, 1);
    vecs[2]  = mk(FS_SUB, 8'h07, 8'h07, 8'h00, 1'b1, 1'b1, 1'b0, 2, 1);
    vecs[3]  = mk(FS_SRA, 8'h90, 8'h03, 8'hF2, 1'b0, 1'b0, 1'b0, 4, 3);
    vecs[4]  = mk(FS_SLL, 8'h81, 8'h09, 8'h02, 1'b1, 1'b0, 1'b0, 2, 1);
    vecs[5]  = mk(FS_SRL, 8'h0F, 8'h00, 8'h0F, 1'b0, 1'b0, 1'b0, 1, 0);
    vecs[6]  = mk(FS_NOP, 8'h12, 8'h34, 8'h00, 1'b0, 1'b1, 1'b1, 1, 0);
    vecs[7]  = mk(FS_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 2, 1);
    vecs[8]  = mk(FS_OR,  8'h0A, 8'h50, 8'h5A, 1'b0, 1'b0, 1'b0, 2, 1);
    vecs[9]  = mk(FS_SRL, 8'h80, 8'h07, 8'h01, 1'b0, 1'b0, 1'b0, 8, 7);
    vecs[10] = mk(FS_SLL, 8'h01, 8'h07, 8'h80, 1'b0, 1'b0, 1'b0, 8, 7);
    vecs[11] = mk(FS_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 2, 1);
    vecs[12] = mk(FS_SRA, 8'h80, 8'hF9, 8'hC0, 1'b0, 1'b0, 1'b0, 2, 1);

    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_fs    = 3'b000;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkResetState("reset");

    // rsp_ready with nothing pending must not disturb the idle state
    bus.rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    bus.rsp_ready = 1'b0;
    checkVal("stray_ready_valid", 32'(bus.rsp_valid), 32'(0));
    checkVal("stray_ready_cmd_ready", 32'(bus.cmd_ready), 32'(1));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i));
    end

    // Backpressure: response held while a second command waits
    v = mk(FS_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 2, 1);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_fs    = FS_AND;
    bus.cmd_a     = 8'hF0;
    bus.cmd_b     = 8'h3C;
    expQ.push_back(expOf(v));
    @(posedge clk);
    @(negedge clk);
    bus.cmd_fs = FS_OR;
    bus.cmd_a  = 8'h0A;
    bus.cmd_b  = 8'h50;
    waitResponse(v);
    for (int k = 0; k < 5; k++) begin
      checkVal($sformatf("bp_valid_%0d", k), 32'(bus.rsp_valid), 32'(1));
      checkVal($sformatf("bp_y_%0d", k),     32'(bus.rsp_y),     32'(8'h30));
      checkVal($sformatf("bp_ready_%0d", k), 32'(bus.cmd_ready), 32'(0));
      @(negedge clk);
    end
    checkOutput("bp_and");
    checkVal("bp_second_pending_busy", 32'(bus.busy), 32'(0));
    expQ.push_back(expOf(mk(FS_OR, 8'h0A, 8'h50, 8'h5A, 1'b0, 1'b0, 1'b0, 2, 1)));
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    checkVal("bp_second_accepted", 32'(bus.busy), 32'(1));
    waitResponse(mk(FS_OR, 8'h0A, 8'h50, 8'h5A, 1'b0, 1'b0, 1'b0, 2, 1));
    checkOutput("bp_or");

    // Reset during the second SHIFT cycle of SLL 01 by 7 abandons the command
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_fs    = FS_SLL;
    bus.cmd_a     = 8'h01;
    bus.cmd_b     = 8'h07;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    checkVal("rst_mid_shifting", 32'(bus.alu_fs), 32'(FS_SLL));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkResetState("rst_mid");
    highs = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) highs++;
    end
    checkVal("rst_mid_no_response", 32'(highs), 32'(0));
    w = 0;
    applyStimulus(mk(FS_OR, 8'h0A, 8'h50, 8'h5A, 1'b0, 1'b0, 1'b0, 2, 1));
    checkOutput("post_reset_or");

    checkVal("scoreboard_empty", 32'(expQ.size()), 32'(w));
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
